// File: rtl/seg_pkg.sv
// Shared 7-segment constants and BCD sizing helpers for the scan-mux display slice.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    // {dp,g,f,e,d,c,b,a} codes for decimal digits 0..9
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Pin-side bundle between game logic (master) and the display driver (slave).
interface seg_scan_mux_if #(
    parameter int DIGITS = 8,
    parameter int WA     = 5,
    parameter int WB     = 6
);
    logic              enable;
    logic [WA-1:0]     val_a;
    logic [WB-1:0]     val_b;
    logic              lzb_en;
    logic              blink_a;
    logic              blink_b;
    logic [DIGITS-1:0] dp_mask;
    logic [DIGITS-1:0] num_row;
    logic [7:0]        num_Rcol;
    logic              frame_sync;

    modport master (
        output enable, val_a, val_b, lzb_en, blink_a, blink_b, dp_mask,
        input  num_row, num_Rcol, frame_sync
    );

    modport slave (
        input  enable, val_a, val_b, lzb_en, blink_a, blink_b, dp_mask,
        output num_row, num_Rcol, frame_sync
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads bin, W shift/add-3 cycles later bcd/ovf update and done rises.
// Latency W+1 cycles from start; no backpressure, a new start simply restarts the conversion.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int W = 5,
    parameter int D = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W-1:0]            bin,
    output logic [bcd_width(D)-1:0] bcd,
    output logic                    ovf,
    output logic                    done
);
    localparam int                       BW       = bcd_width(D);
    localparam int                       CW       = $clog2(W + 1);
    localparam logic [CW-1:0]            CNT_LAST = CW'(W - 1);
    localparam longint unsigned          LIMIT    = pow10(D);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sreg_q;
    logic [BW-1:0]   work_q, adj, work_d;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < D; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Carry out of the top digit is dropped; only matters when ovf is set.
    assign adj    = add3(work_q);
    assign work_d = BW'({adj, sreg_q[W-1]});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start)                                        state_d = S_SHIFT;
        else if (state_q == S_SHIFT && cnt_q == CNT_LAST) state_d = S_IDLE;
    end

    // Working registers are separate from bcd/ovf so an aborted run never leaks out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            sreg_q <= bin;
            work_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= (64'(bin) >= LIMIT);
            done   <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            work_q <= work_d;
            sreg_q <= sreg_q << 1;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
                bcd  <= work_d;
                ovf  <= ovf_q;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment driver for two decimal fields; rows/segments registered, display lags input by <=2 frames+1.
// No backpressure: free-running scan, frame-synchronous snapshot of val_a/val_b.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DA           = 2,
    parameter int DB           = 2,
    parameter int WA           = 5,
    parameter int WB           = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input logic           clk,
    input logic           rst,
    seg_scan_mux_if.slave bus
);
    localparam int BWA   = bcd_width(DA);
    localparam int BWB   = bcd_width(DB);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    if (DA + DB > DIGITS) begin : g_bad_fields
        $error("seg_scan_mux: DA+DB exceeds DIGITS");
    end
    if (WA + 2 > SCAN_DIV * DIGITS || WB + 2 > SCAN_DIV * DIGITS) begin : g_bad_conv
        $error("seg_scan_mux: conversion does not fit in one frame");
    end

    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [BLK_W-1:0] blk_q;
    logic             phase_q, phase_d, fs;
    logic [BWA-1:0]   conv_a, disp_a, disp_a_d;
    logic [BWB-1:0]   conv_b, disp_b, disp_b_d;
    logic             ovf_a, ovf_a_q, ovf_a_d, done_a;
    logic             ovf_b, ovf_b_q, ovf_b_d, done_b;
    logic [7:0]       pos_seg [DIGITS];
    logic [DIGITS-1:0] row_q;
    logic [7:0]       col_q;

    assign fs             = rst & bus.enable & (div_q == '0) & (idx_q == '0);
    assign bus.frame_sync = fs;
    assign bus.num_row    = row_q;
    assign bus.num_Rcol   = col_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (!bus.enable) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign phase_d = (fs && blk_q == BLK_LAST) ? ~phase_q : phase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_q   <= '0;
            phase_q <= 1'b0;
        end else if (fs) begin
            blk_q   <= (blk_q == BLK_LAST) ? '0 : blk_q + BLK_W'(1);
            phase_q <= phase_d;
        end
    end

    bin2bcd_seq #(.W(WA), .D(DA)) u_conv_a (
        .clk(clk), .rst(rst), .start(fs), .bin(bus.val_a),
        .bcd(conv_a), .ovf(ovf_a), .done(done_a)
    );

    bin2bcd_seq #(.W(WB), .D(DB)) u_conv_b (
        .clk(clk), .rst(rst), .start(fs), .bin(bus.val_b),
        .bcd(conv_b), .ovf(ovf_b), .done(done_b)
    );

    // Render from the next-state display so digit 0 of a new frame already uses the new content.
    assign disp_a_d = (fs && done_a) ? conv_a : disp_a;
    assign ovf_a_d  = (fs && done_a) ? ovf_a  : ovf_a_q;
    assign disp_b_d = (fs && done_b) ? conv_b : disp_b;
    assign ovf_b_d  = (fs && done_b) ? ovf_b  : ovf_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_a  <= '0;
            disp_b  <= '0;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
        end else begin
            disp_a  <= disp_a_d;
            disp_b  <= disp_b_d;
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
        end
    end

    function automatic logic [7:0] field_seg(input logic [3:0] dig, input logic upper_zero,
                                             input logic is_lsd, input logic ovf,
                                             input logic lzb, input logic dark);
        logic [7:0] code;
        if (ovf)                               code = SEG_DASH;
        else if (lzb && upper_zero && !is_lsd) code = SEG_BLANK;
        else if (dig <= 4'd9)                  code = SEG_DIGIT[dig];
        else                                   code = SEG_BLANK;
        if (dark) code = SEG_BLANK;
        return code;
    endfunction

    for (genvar d = 0; d < DIGITS; d++) begin : g_pos
        if (d < DA) begin : g_a
            assign pos_seg[d] = field_seg(disp_a_d[4*d +: 4], disp_a_d[BWA-1:4*d] == '0,
                                          d == 0, ovf_a_d, bus.lzb_en,
                                          bus.blink_a & phase_d);
        end else if (d >= DIGITS - DB) begin : g_b
            localparam int J = d - (DIGITS - DB);
            assign pos_seg[d] = field_seg(disp_b_d[4*J +: 4], disp_b_d[BWB-1:4*J] == '0,
                                          J == 0, ovf_b_d, bus.lzb_en,
                                          bus.blink_b & phase_d);
        end else begin : g_none
            assign pos_seg[d] = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '1;
            col_q <= SEG_BLANK;
        end else if (!bus.enable) begin
            row_q <= '1;
            col_q <= SEG_BLANK;
        end else begin
            row_q <= ~(DIGITS'(1) << idx_q);
            col_q <= pos_seg[idx_q] | {bus.dp_mask[idx_q], 7'b0};
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux against a decimal-arithmetic display model.
module tb_seg_scan_mux;
    localparam int DIGITS = 8;
    localparam int SD     = 4;
    localparam int BF     = 2;
    localparam int FRAME  = SD * DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.DIGITS(DIGITS), .WA(5), .WB(6)) bus0 ();
    seg_scan_mux_if #(.DIGITS(DIGITS), .WA(5), .WB(6)) bus1 ();

    seg_scan_mux #(.DIGITS(DIGITS), .DA(2), .DB(2), .WA(5), .WB(6),
                   .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seg_scan_mux #(.DIGITS(DIGITS), .DA(1), .DB(2), .WA(5), .WB(6),
                   .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.enable  = bus0.enable;
    assign bus1.val_a   = bus0.val_a;
    assign bus1.val_b   = bus0.val_b;
    assign bus1.lzb_en  = bus0.lzb_en;
    assign bus1.blink_a = bus0.blink_a;
    assign bus1.blink_b = bus0.blink_b;
    assign bus1.dp_mask = bus0.dp_mask;

    logic [7:0] code_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since the scan (re)started, frames seen, value pipeline.
    int en_cnt, frame_no, snap_a, snap_b, disp_a, disp_b;
    bit phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ipow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] render(input int pos, input int da, input int db,
                                          input int va, input int vb, input bit ph,
                                          input bit lzb, input bit bla, input bit blb,
                                          input logic [7:0] dp);
        logic [7:0] s;
        int v, j, nd;
        bit own, bl;
        s = 8'h00; own = 0; v = 0; j = 0; nd = 1; bl = 0;
        if (pos < da) begin
            own = 1; v = va; j = pos; nd = da; bl = bla;
        end else if (pos >= DIGITS - db) begin
            own = 1; v = vb; j = pos - (DIGITS - db); nd = db; bl = blb;
        end
        if (own) begin
            if (v >= ipow10(nd))                     s = 8'h40;
            else if (lzb && j > 0 && v < ipow10(j))  s = 8'h00;
            else                                     s = code_tab[(v / ipow10(j)) % 10];
            if (ph && bl) s = 8'h00;
        end
        if (dp[pos]) s[7] = 1'b1;
        return s;
    endfunction

    task automatic step();
        logic [7:0] e_row, e_col0, e_col1;
        bit e_fs;
        int idx;
        @(negedge clk);
        if (bus0.enable) begin
            e_fs = (en_cnt % FRAME) == 0;
            if (e_fs) begin
                frame_no++;
                disp_a = snap_a;
                disp_b = snap_b;
                snap_a = int'(bus0.val_a);
                snap_b = int'(bus0.val_b);
                phase  = ((frame_no / BF) % 2) == 1;
            end
            idx    = (en_cnt % FRAME) / SD;
            e_row  = ~(8'h01 << idx);
            e_col0 = render(idx, 2, 2, disp_a, disp_b, phase, bus0.lzb_en,
                            bus0.blink_a, bus0.blink_b, bus0.dp_mask);
            e_col1 = render(idx, 1, 2, disp_a, disp_b, phase, bus0.lzb_en,
                            bus0.blink_a, bus0.blink_b, bus0.dp_mask);
            en_cnt++;
        end else begin
            e_fs = 0; en_cnt = 0; e_row = 8'hFF; e_col0 = 8'h00; e_col1 = 8'h00;
        end
        check_eq("frame_sync", 32'(bus0.frame_sync), 32'(e_fs));
        @(posedge clk);
        #1;
        check_eq("num_row", 32'(bus0.num_row), 32'(e_row));
        check_eq("num_Rcol", 32'(bus0.num_Rcol), 32'(e_col0));
        check_eq("num_Rcol_da1", 32'(bus1.num_Rcol), 32'(e_col1));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic spot(input string tag, input bit inst, input logic [7:0] row,
                        input logic [7:0] col);
        bit found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            step();
            if ((inst ? bus1.num_row : bus0.num_row) == row) begin
                found = 1;
                check_eq(tag, 32'(inst ? bus1.num_Rcol : bus0.num_Rcol), 32'(col));
            end
        end
        if (!found) check_eq({tag, "_row_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_eq("rst_row", 32'(bus0.num_row), 32'hFF);
        check_eq("rst_col", 32'(bus0.num_Rcol), 32'h00);
        check_eq("rst_fs", 32'(bus0.frame_sync), 32'h0);
        check_eq("rst_col_da1", 32'(bus1.num_Rcol), 32'h00);
        en_cnt = 0; frame_no = 0; snap_a = 0; snap_b = 0; disp_a = 0; disp_b = 0; phase = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hold_row", 32'(bus0.num_row), 32'hFF);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.enable = 1'b1; bus0.val_a = 5'd17; bus0.val_b = 6'd45;
        bus0.lzb_en = 1'b0; bus0.blink_a = 1'b0; bus0.blink_b = 1'b0; bus0.dp_mask = 8'h00;
        #2;
        do_reset();

        run(3 * FRAME);
        spot("norm_p0", 0, 8'hFE, 8'h07);
        spot("norm_p1", 0, 8'hFD, 8'h06);
        spot("norm_p2", 0, 8'hFB, 8'h00);
        spot("norm_p5", 0, 8'hDF, 8'h00);
        spot("norm_p6", 0, 8'hBF, 8'h6D);
        spot("norm_p7", 0, 8'h7F, 8'h66);

        bus0.val_a = 5'd5; bus0.val_b = 6'd0; bus0.lzb_en = 1'b1;
        run(2 * FRAME + 1);
        spot("lzb_p0", 0, 8'hFE, 8'h6D);
        spot("lzb_p1", 0, 8'hFD, 8'h00);
        spot("lzb_p6", 0, 8'hBF, 8'h3F);
        spot("lzb_p7", 0, 8'h7F, 8'h00);

        bus0.lzb_en = 1'b0; bus0.val_a = 5'd12; bus0.val_b = 6'd45; bus0.dp_mask = 8'h40;
        run(2 * FRAME + 1);
        spot("dp_p6", 0, 8'hBF, 8'hED);
        spot("ovf_da1_p0", 1, 8'hFE, 8'h40);

        bus0.dp_mask = 8'h00; bus0.blink_b = 1'b1;
        run(8 * FRAME);
        bus0.blink_b = 1'b0;

        bus0.enable = 1'b0;
        run(15);
        bus0.enable = 1'b1;
        run(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)   bus0.val_a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0)   bus0.val_b = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 39) == 0)  bus0.lzb_en = ~bus0.lzb_en;
            if ($urandom_range(0, 49) == 0)  bus0.blink_a = ~bus0.blink_a;
            if ($urandom_range(0, 49) == 0)  bus0.blink_b = ~bus0.blink_b;
            if ($urandom_range(0, 29) == 0)  bus0.dp_mask = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) begin
                bus0.enable = 1'b0;
                run($urandom_range(12, 20));
                bus0.enable = 1'b1;
            end
            step();
        end

        for (int k = 0; k < FRAME && (en_cnt % FRAME) != 3; k++) step();
        bus0.val_a = 5'd29; bus0.val_b = 6'd63;
        do_reset();
        run(3 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed 7-segment display driver for the board's common-cathode digit bank. It shows two independent binary fields, for example score and countdown time, as decimal digits in a DIGITS-position strip. Each field is converted to BCD internally by a sequential double-dabble. The block adds a programmable per-digit dwell, leading-zero blanking, per-field blink, per-digit decimal points and overflow indication. It sits between the game-logic counters and the board pins.

## Interface
- DIGITS, 8: number of multiplexed digit positions.
- DA, 2: decimal digits of field A, placed at positions 0..DA-1.
- DB, 2: decimal digits of field B, placed at positions DIGITS-DB..DIGITS-1.
- WA, 5: binary width of val_a.
- WB, 6: binary width of val_b.
- SCAN_DIV, 1000: clk cycles each digit stays selected; must be ≥1.
- BLINK_FRAMES, 64: frames per blink half-period; must be ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = scan; 0 = display dark and scan held at digit 0.
- val_a  in  WA  field A binary value.
- val_b  in  WB  field B binary value.
- lzb_en  in  1  leading-zero blanking for both fields.
- blink_a, blink_b  in  1  blink the respective field.
- dp_mask  in  DIGITS  bit d lights the DP of position d.
- num_row  out  DIGITS  digit select, active-low, one-hot-zero.
- num_Rcol  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- frame_sync  out  1  one-cycle pulse at frame start.

## Operation
- Elaboration error if DA+DB > DIGITS, or if WA+2 or WB+2 exceeds SCAN_DIV*DIGITS.
- A divider counts 0..SCAN_DIV-1. At its terminal count, the digit index advances and wraps DIGITS-1 → 0. frame_sync pulses on the wrap cycle.
- On frame_sync, two actions happen together:
  - Both display BCD registers load the results of the conversions started at the previous frame_sync.
  - val_a and val_b are snapshotted and new conversions start.
- Display content is therefore constant for a whole frame (no tearing). A mid-frame input change has no effect until two frame_syncs later.
- Conversion is double-dabble: 1 load cycle plus W shift/add-3 cycles, then a done flag.
- Overflow: if val_a ≥ 10^DA, every field A digit shows '-' (8'h40). Same rule for field B against 10^DB.
- Leading-zero blanking (lzb_en=1): within a field, zero digits above the most significant nonzero digit show 8'h00. The field's position 0 digit is never blanked. Blanking is not applied to overflow dashes.
- Blink: a frame counter toggles blink phase every BLINK_FRAMES frames. When phase=1 and blink_x=1, that field's segments a–g are forced to 0. DP and row scanning continue.
- Positions not owned by either field show segments 0.
- The DP bit is dp_mask[d] for the active digit d, independent of field state.
- Digit codes 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F; these go in the package.
- enable=0:
  - num_row all ones, num_Rcol 0.
  - Divider and index cleared, frame_sync low; conversions may finish.
  - On re-enable, the scan restarts with digit 0 and a frame_sync on the first enabled cycle.

## Timing
- Reset values: num_row all ones, num_Rcol 8'h00, frame_sync 0. Divider, index, blink counter, blink phase, display BCD and snapshots are all 0.
- First enabled cycle after reset release: frame_sync=1. num_row/num_Rcol show digit 0 from the next edge.
- num_row and num_Rcol are registered and change on the same edge, one cycle after the index update. There is no cycle in which two rows are low.
- Latency from a stable input to the display is ≤ 2 frames + 1 cycle.
- Reset mid-frame or mid-conversion aborts immediately. No partial BCD ever reaches the display registers.

## Structure
- Package seg_pkg holds:
  - the SEG_DIGIT[0:9] code table;
  - SEG_BLANK = 8'h00 and SEG_DASH = 8'h40;
  - a function computing the BCD width needed for a given digit count.
- Sub-module bin2bcd_seq (parameters W, D): start/done handshake plus overflow flag. Instantiated once per field.

## Test plan
Defaults except SCAN_DIV=4 and BLINK_FRAMES=2.
- Reset and enable: hold rst=0 → num_row=8'hFF, num_Rcol=00. Release with enable=1 → frame_sync at cycle 1; num_row cycles FE,FD,…,7F, 4 cycles each.
- Normal display: val_a=17, val_b=45, lzb_en=0. From frame 3 on, the rows read:
  - FE → 07
  - FD → 06
  - FB..DF → 00
  - BF → 6D
  - 7F → 66
- Leading-zero blanking: val_a=5, val_b=0, lzb_en=1 → FE→6D, FD→00, BF→3F, 7F→00.
- Overflow and DP: instance with DA=1, val_a=12 → FE→40. Separately, dp_mask=8'h40 with val_b=45 → BF→ED.
- Blink: blink_b=1 → positions 6 and 7 show 00 for 2 frames, then digits for 2 frames, repeating; field A is unaffected.
- No tearing and reset abort:
  - val_a changes mid-frame → all digits within each frame come from one snapshot.
  - rst low mid-conversion → outputs return to reset values in the same cycle, with no stale digit afterwards.
